// File: rtl/io_bus_master_if.sv
// io_bus_master_if: CPU request/response handshake plus bus address/control lines
interface io_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              bus_bc;
    logic [ADDR_W-1:0] bus_addr;
    logic [CTRL_W-1:0] bus_ctrl;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, bus_bc, bus_addr, bus_ctrl
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, bus_bc, bus_addr, bus_ctrl
    );
endinterface

// File: rtl/io_bus_master.sv
// io_bus_master: single-outstanding load/store bridge onto the IO bus; IO_BUS_MISALIGN_CHECK_EN enables the alignment check and ERR state
module io_bus_master #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 4,
    parameter int RAM_WAIT = 1,
    parameter int IO_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    io_bus_master_if.master   io,
    inout  wire  [DATA_W-1:0] bus_data
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
`ifdef IO_BUS_MISALIGN_CHECK_EN
        ERR,
`endif
        DONE
    } state_t;

    state_t            state, nxt;
    logic [3:0]        cnt;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, cap, lanes, ext;
    logic [7:0]        byte_l;
    logic [15:0]       half_l;
    logic              active;
    logic [3:0]        wait_n;

    assign active = state == SETUP || state == WAIT;
    assign wait_n = &addr_q[ADDR_W-1:12] ? 4'(IO_WAIT) : 4'(RAM_WAIT);
    assign lanes  = size_q == 2'b00 ? {(DATA_W/8){wdata_q[7:0]}} :
                    size_q == 2'b01 ? {(DATA_W/16){wdata_q[15:0]}} : wdata_q;
    assign byte_l = cap[{addr_q[1:0], 3'b000} +: 8];
    assign half_l = cap[{addr_q[1], 4'b0000} +: 16];
    assign ext    = size_q == 2'b00 ? {{(DATA_W-8){byte_l[7] & ~uns_q}}, byte_l} :
                    size_q == 2'b01 ? {{(DATA_W-16){half_l[15] & ~uns_q}}, half_l} : cap;
    assign bus_data = active && we_q ? lanes : 'z;

`ifdef IO_BUS_MISALIGN_CHECK_EN
    logic mis;
    assign mis = (io.req_size == 2'b01 && io.req_addr[0]) || (io.req_size[1] && io.req_addr[1:0] != 2'b00);
`endif

    // State register; reset aborts any bus cycle at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state: SETUP runs once, WAIT counts down to 1, DONE/ERR last one cycle
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (io.req_valid) nxt = SETUP;
`ifdef IO_BUS_MISALIGN_CHECK_EN
                if (io.req_valid && mis) nxt = ERR;
`endif
            end
            SETUP:   nxt = wait_n == 4'd0 ? DONE : WAIT;
            WAIT:    nxt = cnt <= 4'd1 ? DONE : WAIT;
            default: nxt = IDLE;
        endcase
    end

    // Request latch, wait counter and load-data capture on the last bus cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            cap     <= '0;
        end else begin
            if (state == IDLE && io.req_valid) begin
                we_q    <= io.req_we;
                uns_q   <= io.req_unsigned;
                size_q  <= io.req_size == 2'b11 ? 2'b10 : io.req_size;
                addr_q  <= io.req_addr;
                wdata_q <= io.req_wdata;
            end
            if (state == SETUP)     cnt <= wait_n;
            else if (state == WAIT) cnt <= cnt - 4'd1;
            if (active && nxt == DONE) cap <= bus_data;
        end
    end

    // Handshake, response and bus control outputs decoded from state
    always_comb begin
        io.req_ready  = state == IDLE && !rst;
        io.resp_valid = state == DONE;
        io.resp_err   = 1'b0;
`ifdef IO_BUS_MISALIGN_CHECK_EN
        io.resp_valid = state == DONE || state == ERR;
        io.resp_err   = state == ERR;
`endif
        io.resp_rdata    = state == DONE && !we_q ? ext : '0;
        io.bus_bc        = active;
        io.bus_addr      = active ? (size_q[1] ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q) : '0;
        io.bus_ctrl      = '0;
        io.bus_ctrl[3:0] = active ? {size_q, we_q, ~we_q} : 4'b0000;
    end
endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: directed vector bench for io_bus_master with a parking bus model
module tb_io_bus_master;
    localparam logic [31:0] PARK = 32'h5A5A_5A5A;
`ifdef IO_BUS_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_bus_master_if io ();
    io_bus_master_if io0 ();
    wire  [31:0] bus_data, bus_data0;
    logic [31:0] rsp = '0, rsp0 = '0;

    // Bus model: answers reads during a bus cycle, parks a pattern whenever no cycle runs
    assign bus_data  = (!io.bus_bc || io.bus_ctrl[0]) ? (io.bus_bc ? rsp : PARK) : 'z;
    assign bus_data0 = (!io0.bus_bc || io0.bus_ctrl[0]) ? (io0.bus_bc ? rsp0 : PARK) : 'z;

    io_bus_master dut (.clk(clk), .rst(rst), .io(io), .bus_data(bus_data));
    io_bus_master #(.RAM_WAIT(0), .IO_WAIT(0)) dut0 (.clk(clk), .rst(rst), .io(io0), .bus_data(bus_data0));

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, wdata, rsp;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  ctrl;
        logic [31:0] baddr, bdata;
    } vec_t;

    vec_t v[10];

    task automatic txn(input vec_t t, input int idx);
        int lat = 0, good = 0;
        @(negedge clk);
        check($sformatf("v%0d ready", idx), 32'(io.req_ready), 32'd1);
        io.req_valid = 1'b1; io.req_we = t.we; io.req_size = t.size; io.req_unsigned = t.uns;
        io.req_addr = t.addr; io.req_wdata = t.wdata; rsp = t.rsp;
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            if (io.resp_valid) lat = k;
            else if (io.bus_bc && io.bus_ctrl == t.ctrl && io.bus_addr == t.baddr && (!t.we || bus_data == t.bdata)) good++;
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(t.lat));
        check($sformatf("v%0d rdata", idx), io.resp_rdata, t.rdata);
        check($sformatf("v%0d err", idx), 32'(io.resp_err), 32'(t.err));
        check($sformatf("v%0d stable bus cycles", idx), 32'(good), 32'(t.lat - 1));
        check($sformatf("v%0d bc at resp", idx), 32'(io.bus_bc), 32'd0);
        check($sformatf("v%0d ctrl at resp", idx), 32'(io.bus_ctrl), 32'd0);
        check($sformatf("v%0d ready at resp", idx), 32'(io.req_ready), 32'd0);
        check($sformatf("v%0d data released", idx), bus_data, PARK);
        @(negedge clk);
        check($sformatf("v%0d resp one cycle", idx), 32'(io.resp_valid), 32'd0);
    endtask

    initial begin
        int mask = 0, nresp = 0;
        io.req_valid = 0; io.req_we = 0; io.req_size = 0; io.req_unsigned = 0; io.req_addr = 0; io.req_wdata = 0;
        io0.req_valid = 0; io0.req_we = 0; io0.req_size = 0; io0.req_unsigned = 0; io0.req_addr = 0; io0.req_wdata = 0;
        v[0] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0, 4'b1001, 32'h100, 32'h0};
        v[1] = '{1'b0, 2'b00, 1'b0, 32'hFFFFF063, 32'h0, 32'h80FFFFFF, 4, 32'hFFFFFF80, 1'b0, 4'b0001, 32'hFFFFF063, 32'h0};
        v[2] = '{1'b0, 2'b00, 1'b1, 32'hFFFFF063, 32'h0, 32'h80FFFFFF, 4, 32'h00000080, 1'b0, 4'b0001, 32'hFFFFF063, 32'h0};
        v[3] = '{1'b1, 2'b01, 1'b0, 32'hFFFFF002, 32'h1234ABCD, 32'h0, 4, 32'h0, 1'b0, 4'b0110, 32'hFFFFF002, 32'hABCDABCD};
        v[4] = '{1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h80017FFF, 3, 32'hFFFF8001, 1'b0, 4'b0101, 32'h202, 32'h0};
        v[5] = '{1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFF3C, 32'h0, 3, 32'h0, 1'b0, 4'b0010, 32'h5, 32'h3C3C3C3C};
        v[6] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h01234567, 32'h0, 3, 32'h0, 1'b0, 4'b1010, 32'h10, 32'h01234567};
        v[7] = '{1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 32'h0000F200, 3, 32'h000000F2, 1'b0, 4'b0001, 32'h1, 32'h0};
        v[8] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h11223344, MIS ? 1 : 3, MIS ? 32'h0 : 32'h11223344,
                 MIS, MIS ? 4'b0000 : 4'b1001, 32'h100, 32'h0};
        v[9] = '{1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 32'hA5A51234, MIS ? 1 : 3, MIS ? 32'h0 : 32'hFFFFA5A5,
                 MIS, MIS ? 4'b0000 : 4'b0101, 32'h203, 32'h0};

        @(negedge clk);
        check("reset ready", 32'(io.req_ready), 32'd0);
        check("reset resp_valid", 32'(io.resp_valid), 32'd0);
        check("reset rdata", io.resp_rdata, 32'd0);
        check("reset err", 32'(io.resp_err), 32'd0);
        check("reset bc", 32'(io.bus_bc), 32'd0);
        check("reset addr", io.bus_addr, 32'd0);
        check("reset ctrl", 32'(io.bus_ctrl), 32'd0);
        check("reset data", bus_data, PARK);
        rst = 1'b0;
        #1 check("ready after reset", 32'(io.req_ready), 32'd1);

        for (int i = 0; i < 10; i++) txn(v[i], i);

        // Reset during the WAIT phase of a peripheral store
        @(negedge clk);
        io.req_valid = 1'b1; io.req_we = 1'b1; io.req_size = 2'b10; io.req_addr = 32'hFFFFF010; io.req_wdata = 32'h77778888;
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort store data", bus_data, 32'h77778888);
        check("abort store bc", 32'(io.bus_bc), 32'd1);
        rst = 1'b1;
        #1;
        check("abort data released", bus_data, PARK);
        check("abort ctrl", 32'(io.bus_ctrl), 32'd0);
        check("abort bc", 32'(io.bus_bc), 32'd0);
        check("abort ready in reset", 32'(io.req_ready), 32'd0);
        check("abort resp_valid", 32'(io.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("abort ready after release", 32'(io.req_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            if (io.resp_valid) nresp++;
        end
        check("abort no resp", 32'(nresp), 32'd0);

        // Back-to-back zero-wait word loads with req_valid held high
        @(negedge clk);
        io0.req_valid = 1'b1; io0.req_size = 2'b10; io0.req_addr = 32'h40; rsp0 = 32'hCAFEF00D;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (io0.resp_valid) begin
                mask |= 1 << k;
                check($sformatf("b2b rdata c%0d", k), io0.resp_rdata, 32'hCAFEF00D);
            end
            if (k == 7) io0.req_valid = 1'b0;
        end
        check("b2b resp cycles", 32'(mask), 32'h124);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
